// File: rtl/timer_pkg.sv
// ----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the timer bank: the per-channel state encoding,
// the one-shot / auto-reload mode constants and a width helper used to size
// the prescaler and channel-select fields.
// No ports (package).
// ----------------------------------------------------------------------------
package timer_pkg;

  // Per-channel run state
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } ch_state_e;

  // Channel mode: one-shot stops at expiry, reload restarts from the reload value
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  // Bits needed to index n items, never less than one
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// ----------------------------------------------------------------------------
// timer_channel
// One countdown channel of the timer bank. Holds count, reload value, mode and
// a prescaler; counts down one unit every PRESCALE cycles while running and
// flags expiry when a tick lands on count == 1.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   i_load             load strobe already decoded for this channel
//   i_load_val         value written to count and reload
//   i_load_mode        MODE_ONESHOT / MODE_RELOAD
//   i_start            start (from IDLE) or resume (from PAUSED)
//   i_stop             pause while running
//   i_clr              clear the sticky expired flag
//   o_expired          sticky expiry flag
//   o_expired_pulse    one-cycle expiry pulse
//   o_running          high while in RUN
//   o_count            current count
// ----------------------------------------------------------------------------
module timer_channel
  import timer_pkg::*;
#(
  parameter  int CNT_W    = 16,
  parameter  int PRESCALE = 5,
  localparam int PRE_W    = width_of(PRESCALE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_load_mode,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_clr,
  output logic             o_expired,
  output logic             o_expired_pulse,
  output logic             o_running,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  ch_state_e        r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_reload;
  logic             r_mode;
  logic [PRE_W-1:0] r_pre;
  logic             r_expired;
  logic             r_pulse;
  logic             r_running;

  logic w_tick;
  logic w_expire;

  // A tick only happens in RUN when neither a load nor a stop overrides it
  assign w_tick   = (r_state == RUN) && !i_load && !i_stop && (r_pre == PRE_LAST);
  assign w_expire = w_tick && (r_count == CNT_W'(1));

  // Channel state machine, counters and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_reload  <= '0;
      r_mode    <= MODE_ONESHOT;
      r_pre     <= '0;
      r_expired <= 1'b0;
      r_pulse   <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_pulse <= w_expire;

      // Expiry beats a coincident clear; load leaves the flag alone
      if (w_expire) begin
        r_expired <= 1'b1;
      end else if (i_clr) begin
        r_expired <= 1'b0;
      end else begin
        r_expired <= r_expired;
      end

      if (i_load) begin
        r_count   <= i_load_val;
        r_reload  <= i_load_val;
        r_mode    <= i_load_mode;
        r_pre     <= '0;
        r_state   <= IDLE;
        r_running <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            // The start cycle only arms the channel; counting begins next cycle
            if (i_start && (r_count != '0)) begin
              r_state   <= RUN;
              r_pre     <= '0;
              r_running <= 1'b1;
            end else begin
              r_state   <= IDLE;
              r_running <= 1'b0;
            end
          end
          RUN: begin
            if (i_stop) begin
              r_state   <= PAUSED;
              r_running <= 1'b0;
            end else if (w_tick) begin
              r_pre <= '0;
              if (r_count == CNT_W'(1)) begin
                if (r_mode == MODE_RELOAD) begin
                  // Reload in the same cycle so the period stays exact
                  r_count   <= r_reload;
                  r_state   <= RUN;
                  r_running <= 1'b1;
                end else begin
                  r_count   <= '0;
                  r_state   <= IDLE;
                  r_running <= 1'b0;
                end
              end else begin
                r_count <= r_count - CNT_W'(1);
              end
            end else begin
              r_pre <= r_pre + PRE_W'(1);
            end
          end
          PAUSED: begin
            // Resume keeps the prescaler phase captured at the pause
            if (i_start) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end else begin
              r_state   <= PAUSED;
              r_running <= 1'b0;
            end
          end
          default: begin
            r_state   <= IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_expired       = r_expired;
  assign o_expired_pulse = r_pulse;
  assign o_running       = r_running;
  assign o_count         = r_count;

endmodule

// File: rtl/timer_bank.sv
// ----------------------------------------------------------------------------
// timer_bank
// N_CH independent prescaled countdown timers. Decodes the shared load bus to
// one channel, fans out per-channel commands and muxes one count for readback.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   load, load_ch, load_val,  load strobe, target channel, value and mode
//   load_mode                 (0 one-shot, 1 auto-reload); load_ch >= N_CH ignored
//   start, stop, clr          per-channel start/resume, pause, expired clear
//   expired, expired_pulse    per-channel sticky flag and one-cycle pulse
//   running                   per-channel RUN indicator
//   rd_ch, rd_val             read select and selected channel's count
// ----------------------------------------------------------------------------
module timer_bank
  import timer_pkg::*;
#(
  parameter  int N_CH     = 4,
  parameter  int CNT_W    = 16,
  parameter  int PRESCALE = 5,
  localparam int CH_W     = width_of(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CH_W-1:0]  load_ch,
  input  logic [CNT_W-1:0] load_val,
  input  logic             load_mode,
  input  logic [N_CH-1:0]  start,
  input  logic [N_CH-1:0]  stop,
  input  logic [N_CH-1:0]  clr,
  output logic [N_CH-1:0]  expired,
  output logic [N_CH-1:0]  expired_pulse,
  output logic [N_CH-1:0]  running,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [CNT_W-1:0] rd_val
);

  logic [N_CH-1:0]  w_load;
  logic [CNT_W-1:0] w_count [N_CH];
  logic [CNT_W-1:0] w_rd_val;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      // Out-of-range load_ch matches no channel and is dropped here
      assign w_load[g] = load && (load_ch == CH_W'(g));

      timer_channel #(
        .CNT_W    (CNT_W),
        .PRESCALE (PRESCALE)
      ) u_ch (
        .clk             (clk),
        .rst             (rst),
        .i_load          (w_load[g]),
        .i_load_val      (load_val),
        .i_load_mode     (load_mode),
        .i_start         (start[g]),
        .i_stop          (stop[g]),
        .i_clr           (clr[g]),
        .o_expired       (expired[g]),
        .o_expired_pulse (expired_pulse[g]),
        .o_running       (running[g]),
        .o_count         (w_count[g])
      );
    end
  endgenerate

  // AND-OR read mux; an out-of-range rd_ch reads as zero
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_rd_val = w_rd_val | (w_count[i] & {CNT_W{rd_ch == CH_W'(i)}});
    end
  end

  assign rd_val = w_rd_val;

endmodule

// File: tb/tb_timer_bank.sv
module tb_timer_bank;

  localparam int N_CH     = 4;
  localparam int CNT_W    = 16;
  localparam int PRESCALE = 5;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;

  logic             clk;
  logic             rst;
  logic             load;
  logic [1:0]       load_ch;
  logic [CNT_W-1:0] load_val;
  logic             load_mode;
  logic [N_CH-1:0]  start;
  logic [N_CH-1:0]  stop;
  logic [N_CH-1:0]  clr;
  logic [N_CH-1:0]  expired;
  logic [N_CH-1:0]  expired_pulse;
  logic [N_CH-1:0]  running;
  logic [1:0]       rd_ch;
  logic [CNT_W-1:0] rd_val;

  int vectors;
  int miscompares;

  // Reference model: per-channel behaviour from the rules, tracking how many
  // RUN cycles have elapsed since the last fresh start.
  int m_count   [N_CH];
  int m_reload  [N_CH];
  int m_mode    [N_CH];
  int m_st      [N_CH];
  int m_elapsed [N_CH];
  bit m_exp     [N_CH];
  bit m_pulse   [N_CH];

  timer_bank #(
    .N_CH     (N_CH),
    .CNT_W    (CNT_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .load_ch       (load_ch),
    .load_val      (load_val),
    .load_mode     (load_mode),
    .start         (start),
    .stop          (stop),
    .clr           (clr),
    .expired       (expired),
    .expired_pulse (expired_pulse),
    .running       (running),
    .rd_ch         (rd_ch),
    .rd_val        (rd_val)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic model_step();
    for (int c = 0; c < N_CH; c++) begin
      bit fire;
      fire = 1'b0;
      if (rst) begin
        m_count[c] = 0; m_reload[c] = 0; m_mode[c] = 0;
        m_st[c] = M_IDLE; m_elapsed[c] = 0; m_exp[c] = 1'b0;
      end else begin
        if (load && (int'(load_ch) == c)) begin
          m_count[c] = int'(load_val); m_reload[c] = int'(load_val);
          m_mode[c] = int'(load_mode); m_elapsed[c] = 0; m_st[c] = M_IDLE;
        end else if (m_st[c] == M_RUN) begin
          if (stop[c]) begin
            m_st[c] = M_PAUSED;
          end else begin
            m_elapsed[c] = m_elapsed[c] + 1;
            if (m_elapsed[c] % PRESCALE == 0) begin
              if (m_count[c] > 1) begin
                m_count[c] = m_count[c] - 1;
              end else begin
                fire = 1'b1;
                if (m_mode[c] == 1) m_count[c] = m_reload[c];
                else begin m_count[c] = 0; m_st[c] = M_IDLE; end
              end
            end
          end
        end else if (m_st[c] == M_IDLE && start[c] && m_count[c] > 0) begin
          m_st[c] = M_RUN; m_elapsed[c] = 0;
        end else if (m_st[c] == M_PAUSED && start[c]) begin
          m_st[c] = M_RUN;
        end
        if (fire) m_exp[c] = 1'b1;
        else if (clr[c]) m_exp[c] = 1'b0;
      end
      m_pulse[c] = fire;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic peek(input int ch, output logic [CNT_W-1:0] v);
    rd_ch = 2'(ch);
    #1;
    v = rd_val;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic do_load(input int ch, input int val, input logic mode);
    load = 1'b1; load_ch = 2'(ch); load_val = CNT_W'(val); load_mode = mode;
    cyc();
    load = 1'b0;
  endtask

  task automatic test_reset();
    logic [CNT_W-1:0] v;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    vectors++;
    if ({expired, expired_pulse, running} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want 000", {expired, expired_pulse, running});
    end
    for (int c = 0; c < N_CH; c++) begin
      peek(c, v);
      vectors++;
      if (v !== 16'd0) begin
        miscompares++;
        $display("FAIL reset_count ch%0d got %0d want 0", c, v);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [CNT_W-1:0] v;
    do_reset();
    do_load(0, 3, 1'b0);
    start = 4'b0001;
    cyc();
    start = 4'b0000;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      vectors++;
      if (expired_pulse[0] !== (k == 3 * PRESCALE)) begin
        miscompares++;
        $display("FAIL oneshot_pulse k=%0d got %b want %b", k, expired_pulse[0], k == 3 * PRESCALE);
      end
      vectors++;
      if (running[0] !== (k < 3 * PRESCALE)) begin
        miscompares++;
        $display("FAIL oneshot_running k=%0d got %b want %b", k, running[0], k < 3 * PRESCALE);
      end
      if (k == 3 * PRESCALE) begin
        peek(0, v);
        vectors++;
        if (v !== 16'd0 || expired[0] !== 1'b1) begin
          miscompares++;
          $display("FAIL oneshot_end got count=%0d exp=%b want 0 1", v, expired[0]);
        end
      end
    end
  endtask

  task automatic test_reload();
    logic [CNT_W-1:0] v;
    bit want;
    do_reset();
    do_load(1, 2, 1'b1);
    start = 4'b0010;
    cyc();
    start = 4'b0000;
    for (int k = 1; k <= 33; k++) begin
      cyc();
      want = (k == 10) || (k == 20) || (k == 30);
      vectors++;
      if (expired_pulse[1] !== want) begin
        miscompares++;
        $display("FAIL reload_pulse k=%0d got %b want %b", k, expired_pulse[1], want);
      end
      vectors++;
      if (expired[1] !== (k >= 10) || running[1] !== 1'b1) begin
        miscompares++;
        $display("FAIL reload_flags k=%0d got exp=%b run=%b want %b 1", k, expired[1], running[1], k >= 10);
      end
      if (want) begin
        peek(1, v);
        vectors++;
        if (v !== 16'd2) begin
          miscompares++;
          $display("FAIL reload_value k=%0d got %0d want 2", k, v);
        end
      end
    end
    clr = 4'b0010;
    cyc();
    clr = 4'b0000;
    vectors++;
    if (expired[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL reload_clr got %b want 0", expired[1]);
    end
  endtask

  task automatic test_pause();
    logic [CNT_W-1:0] v;
    int exp_edge;
    exp_edge = 4 * PRESCALE + (27 - 7) + 1;
    do_reset();
    do_load(2, 4, 1'b0);
    start = 4'b0100;
    cyc();
    start = 4'b0000;
    for (int k = 1; k <= 6; k++) cyc();
    stop = 4'b0100;
    cyc();
    stop = 4'b0000;
    for (int k = 8; k <= 26; k++) begin
      cyc();
      peek(2, v);
      vectors++;
      if (v !== 16'd3 || running[2] !== 1'b0 || expired_pulse[2] !== 1'b0) begin
        miscompares++;
        $display("FAIL pause_hold k=%0d got count=%0d run=%b pulse=%b want 3 0 0", k, v, running[2], expired_pulse[2]);
      end
    end
    start = 4'b0100;
    cyc();
    start = 4'b0000;
    vectors++;
    if (running[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL pause_resume got run=%b want 1", running[2]);
    end
    for (int k = 28; k <= 45; k++) begin
      cyc();
      vectors++;
      if (expired_pulse[2] !== (k == exp_edge)) begin
        miscompares++;
        $display("FAIL pause_expiry k=%0d got %b want %b", k, expired_pulse[2], k == exp_edge);
      end
    end
  endtask

  task automatic test_collisions();
    logic [CNT_W-1:0] v;
    do_reset();
    // clear coinciding with the expiry tick
    do_load(0, 1, 1'b0);
    start = 4'b0001;
    cyc();
    start = 4'b0000;
    for (int k = 1; k < PRESCALE; k++) cyc();
    clr = 4'b0001;
    cyc();
    clr = 4'b0000;
    vectors++;
    if (expired[0] !== 1'b1 || expired_pulse[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_vs_set got exp=%b pulse=%b want 1 1", expired[0], expired_pulse[0]);
    end
    // load landing on the tick cycle
    do_load(3, 2, 1'b0);
    start = 4'b1000;
    cyc();
    start = 4'b0000;
    for (int k = 1; k < PRESCALE; k++) cyc();
    load = 1'b1; load_ch = 2'd3; load_val = 16'd9; load_mode = 1'b0;
    cyc();
    load = 1'b0;
    for (int k = 0; k < 10; k++) begin
      peek(3, v);
      vectors++;
      if (v !== 16'd9 || expired_pulse[3] !== 1'b0 || expired[3] !== 1'b0 || running[3] !== 1'b0) begin
        miscompares++;
        $display("FAIL load_vs_tick k=%0d got count=%0d pulse=%b exp=%b run=%b want 9 0 0 0",
                 k, v, expired_pulse[3], expired[3], running[3]);
      end
      cyc();
    end
    // start with a zero count
    do_load(1, 0, 1'b1);
    start = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      cyc();
      vectors++;
      if (running[1:0] !== 2'b00) begin
        miscompares++;
        $display("FAIL start_zero k=%0d got %b want 00", k, running[1:0]);
      end
    end
    start = 4'b0000;
  endtask

  task automatic test_reset_mid();
    logic [CNT_W-1:0] v;
    do_reset();
    for (int c = 0; c < N_CH; c++) do_load(c, 7 + c, 1'b1);
    start = 4'b1111;
    cyc();
    start = 4'b0000;
    for (int k = 0; k < 12; k++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    vectors++;
    if ({expired, expired_pulse, running} !== 12'h000) begin
      miscompares++;
      $display("FAIL midreset_outputs got %h want 000", {expired, expired_pulse, running});
    end
    for (int c = 0; c < N_CH; c++) begin
      peek(c, v);
      vectors++;
      if (v !== 16'd0) begin
        miscompares++;
        $display("FAIL midreset_count ch%0d got %0d want 0", c, v);
      end
    end
    for (int k = 0; k < 60; k++) begin
      cyc();
      vectors++;
      if (expired_pulse !== 4'b0000 || running !== 4'b0000) begin
        miscompares++;
        $display("FAIL midreset_quiet k=%0d got pulse=%b run=%b want 0000 0000", k, expired_pulse, running);
      end
    end
  endtask

  task automatic test_concurrency();
    logic [N_CH-1:0] want;
    do_reset();
    for (int c = 0; c < N_CH; c++) do_load(c, c + 1, 1'b0);
    start = 4'b1111;
    cyc();
    start = 4'b0000;
    for (int k = 1; k <= 25; k++) begin
      cyc();
      for (int c = 0; c < N_CH; c++) want[c] = (k == PRESCALE * (c + 1));
      vectors++;
      if (expired_pulse !== want) begin
        miscompares++;
        $display("FAIL concurrent_pulse k=%0d got %b want %b", k, expired_pulse, want);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      load      = ($urandom_range(0, 9) == 0);
      load_ch   = 2'($urandom_range(0, 3));
      load_val  = CNT_W'($urandom_range(0, 6));
      load_mode = 1'($urandom_range(0, 1));
      for (int c = 0; c < N_CH; c++) begin
        start[c] = ($urandom_range(0, 4) == 0);
        stop[c]  = ($urandom_range(0, 14) == 0);
        clr[c]   = ($urandom_range(0, 9) == 0);
      end
      rd_ch = 2'($urandom_range(0, 3));
      cyc();
      for (int c = 0; c < N_CH; c++) begin
        vectors++;
        if (expired[c] !== m_exp[c] || expired_pulse[c] !== m_pulse[c] ||
            running[c] !== (m_st[c] == M_RUN)) begin
          miscompares++;
          $display("FAIL random_flags n=%0d ch%0d got exp=%b pulse=%b run=%b want %b %b %b",
                   n, c, expired[c], expired_pulse[c], running[c], m_exp[c], m_pulse[c], m_st[c] == M_RUN);
        end
      end
      vectors++;
      if (int'(rd_val) != m_count[rd_ch]) begin
        miscompares++;
        $display("FAIL random_count n=%0d ch%0d got %0d want %0d", n, rd_ch, rd_val, m_count[rd_ch]);
      end
    end
    rst = 1'b0; load = 1'b0; start = '0; stop = '0; clr = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b0; load = 1'b0; load_ch = 2'd0; load_val = '0; load_mode = 1'b0;
    start = '0; stop = '0; clr = '0; rd_ch = 2'd0;
    test_reset();
    test_oneshot();
    test_reload();
    test_pause();
    test_collisions();
    test_reset_mid();
    test_concurrency();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent countdown channels (>=1).
REQ-002 SHALL have parameter CNT_W, default 16: width of each channel's count and reload registers.
REQ-003 SHALL have parameter PRESCALE, default 5: clk cycles per count unit (>=1); PRE_W = max(1, clog2(PRESCALE)); CH_W = max(1, clog2(N_CH)).
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: load  in  1  load strobe; load_ch  in  CH_W  target channel; load_val  in  CNT_W  count value; load_mode  in  1  0 = one-shot, 1 = auto-reload.
REQ-006 SHALL have ports: start  in  N_CH  per-channel start/resume; stop  in  N_CH  per-channel pause; clr  in  N_CH  per-channel expired-flag clear.
REQ-007 SHALL have ports: expired  out  N_CH  sticky flags; expired_pulse  out  N_CH  one-cycle expiry pulses; running  out  N_CH  1 while the channel is in RUN.
REQ-008 SHALL have ports: rd_ch  in  CH_W  read select; rd_val  out  CNT_W  current count of channel rd_ch (combinational mux of registered counts).

Function
REQ-009 SHALL give each channel a state IDLE, RUN or PAUSED, plus registers count, reload, mode and a PRE_W-bit prescaler.
REQ-010 On load with load_ch = c, channel c SHALL set count = reload = load_val, mode = load_mode and prescaler = 0, and SHALL enter IDLE from any state.
REQ-011 A load with load_ch >= N_CH SHALL be ignored.
REQ-012 Per-channel command priority SHALL be load > stop > start.
REQ-013 start[c] in IDLE with count > 0 SHALL enter RUN with prescaler = 0.
REQ-014 start[c] in PAUSED SHALL enter RUN with the prescaler retained.
REQ-015 start[c] with count == 0, or while already in RUN, SHALL be ignored.
REQ-016 stop[c] in RUN SHALL enter PAUSED, freezing count and prescaler; stop[c] in any other state SHALL be ignored.
REQ-017 In RUN, the prescaler SHALL increment each cycle; when it equals PRESCALE-1, it SHALL wrap to 0 and the channel SHALL tick.
REQ-018 With PRESCALE = 1, the channel SHALL tick every RUN cycle.
REQ-019 On a tick with count > 1, count SHALL decrement by 1.
REQ-020 On a tick with count == 1, the channel SHALL assert expired[c] and expired_pulse[c] on the following cycle.
REQ-021 On that expiry tick, a one-shot channel SHALL set count = 0 and enter IDLE; an auto-reload channel SHALL set count = reload and stay in RUN, with no lost cycle.
REQ-022 expired_pulse[c] SHALL be high for exactly one cycle per expiry.
REQ-023 expired[c] SHALL stay high until clr[c]; if clr[c] and an expiry coincide, the set SHALL win.
REQ-024 A load on a channel in the same cycle as its tick SHALL take precedence; no decrement or expiry SHALL occur.
REQ-025 A start in the same cycle as the IDLE-to-RUN transition SHALL NOT cause a decrement in that cycle.
REQ-026 Channels SHALL be fully independent; simultaneous commands to different channels SHALL all take effect.
REQ-027 Load SHALL NOT clear expired.

Reset
REQ-028 rst SHALL have priority over all inputs.
REQ-029 rst SHALL clear all counts, reloads, prescalers and modes (one-shot), and SHALL place every channel in IDLE.
REQ-030 rst SHALL drive expired, expired_pulse and running to 0, including when asserted mid-count; counting SHALL resume only after a new load and start.

Structure
REQ-031 Package timer_pkg SHALL hold the channel state enum typedef (IDLE, RUN, PAUSED) and the mode constants MODE_ONESHOT = 0 and MODE_RELOAD = 1.
REQ-032 Per-channel logic SHALL be a sub-module timer_channel, instantiated N_CH times by a generate loop.
REQ-033 timer_bank SHALL contain only load decode, the read mux and the instances.

Verification (PRESCALE = 5, CNT_W = 16, N_CH = 4)
REQ-034 The bench SHALL cover one-shot expiry: load ch0 = 3 one-shot, then start[0] -> expired_pulse[0] high exactly 15 cycles after the start edge, running[0] drops the same cycle, rd_val = 0.
REQ-035 The bench SHALL cover auto-reload: load ch1 = 2 reload, start -> expired_pulse[1] at 10, 20 and 30 cycles; rd_val reads 2 right after each pulse; expired[1] stays high until clr[1].
REQ-036 The bench SHALL cover pause/resume: ch2 = 4, start, stop after 7 cycles, hold 20 cycles, start -> rd_val constant during pause; expiry 20 + 1 cycles later than with no pause.
REQ-037 The bench SHALL cover collisions: clr[0] in the cycle expired[0] sets -> flag remains 1; load ch3 = 9 on its tick cycle -> rd_val = 9, no pulse; start with count = 0 -> running stays 0.
REQ-038 The bench SHALL cover reset mid-operation: rst while all four channels run -> the next cycle has all outputs 0, all counts 0, and no pulse follows.
REQ-039 The bench SHALL cover concurrency: all four channels started in the same cycle with values 1, 2, 3, 4 -> pulses at 5, 10, 15, 20 cycles respectively.
